dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Two-requester arbiter that shares the single-port DSP data memory (8-bit address, 16-bit word, 144 words, combinational read, write on clock edge when enabled).
- Requester 0 is the DSP core load/store unit. Requester 1 is the host/DMA loader.
- Block performs round-robin arbitration with an optional burst lock, range-checks addresses, and registers read data back to the winner.
- Sits between both requesters and the data memory; it is the memory's only driver.

Parameters:
- DEPTH, 144, number of valid memory words; addresses >= DEPTH are out of range.
- AW, 8, address width.
- DW, 16, data width.
- MAX_LOCK, 16, maximum consecutive grants one requester may hold under lock before forced release.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req0 / req1  in  1  access request, requester 0 / 1
- we0 / we1  in  1  1 = write, 0 = read
- lock0 / lock1  in  1  hold grant on next cycle if still requesting (burst)
- addr0 / addr1  in  AW  word address
- wdata0 / wdata1  in  DW  write data
- gnt0 / gnt1  out  1  combinational grant this cycle; access occurs at this clock edge
- rvalid0 / rvalid1  out  1  registered; read data valid, one cycle after a granted read
- rdata0 / rdata1  out  DW  registered read data
- err0 / err1  out  1  registered; pulses one cycle after a granted out-of-range access
- mem_en  out  1  memory write enable
- mem_addr  out  AW  memory address
- mem_in  out  DW  memory write data
- mem_out  in  DW  memory combinational read data

Behaviour:
- Reset (rst_n low, asynchronous):
  - rvalid*, rdata*, err* = 0.
  - Priority pointer = requester 0.
  - Lock owner = none; lock counter = 0.
  - gnt*, mem_en = 0 while in reset.
- Arbiter states (registered):
  - RR0: priority to requester 0.
  - RR1: priority to requester 1.
  - LOCK0 / LOCK1: lock held by requester 0 / 1.
- Grant logic, combinational, at most one gnt high per cycle:
  - LOCKn with reqn = 1: grant n.
  - LOCKn with reqn = 0: lock dropped; treat the cycle as RR(1-n).
  - RRk: grant k if reqk = 1, else grant the other requester if it is requesting, else no grant.
- Transitions at each edge with a grant to n:
  - lockn = 1 and lock counter < MAX_LOCK-1: go to LOCKn, counter + 1.
  - Otherwise: go to RR(1-n), counter = 0. This is the forced release when the counter saturates.
  - A forced release applies only if the other requester is requesting. If it is not, stay in LOCKn and hold the counter at MAX_LOCK-1.
- No grant: state unchanged except LOCKn with reqn = 0, which moves to RR(1-n).
- Memory drive:
  - mem_addr = granted requester's address; 0 when idle.
  - mem_in = granted requester's write data.
  - mem_en = gnt & we & in_range.
- Range check: in_range = addr < DEPTH.
  - Out-of-range write: suppressed (mem_en = 0).
  - Out-of-range read: returns rdata = 0.
  - Either case: errn = 1 on the next cycle; rvalid is not asserted for an out-of-range read.
- Read path: granted in-range read captures mem_out into rdatan at the edge; rvalidn = 1 for exactly one cycle after the grant.
- Unused response register: rdata holds its last value when rvalid = 0.
- Latency: access completes the cycle gnt is high. Read data arrives 1 cycle later; a new read may be granted every cycle (fully pipelined).
- Requester contract:
  - Requester holds req/we/addr/wdata stable until it sees gnt.
  - A request withdrawn before grant is dropped, with no side effects.
- Simultaneous events:
  - Both requesting in RR0: requester 0 wins.
  - The loser is guaranteed a grant within 1 cycle unlocked, or MAX_LOCK cycles locked.
- Reset mid-burst: lock cleared and pending rvalid/err dropped. A write granted in the cycle rst_n falls is not guaranteed.

Decomposition:
- Shared package dsp_mem_pkg holds:
  - AW, DW, DEPTH constants.
  - State enum (RR0, RR1, LOCK0, LOCK1).
  - Requester index constants (REQ_CORE = 0, REQ_HOST = 1).
- One natural sub-module, dmem_rr_pick: pure combinational two-way round-robin/lock grant select, taking state and reqs and producing the one-hot grant.

Test Plan:
- Reset, then req0 writes addr 5, data 16'hBEEF. Expect gnt0 = 1, mem_en = 1, mem_addr = 5 that cycle. Next cycle req0 reads addr 5: gnt0 = 1, then rvalid0 = 1 and rdata0 = 16'hBEEF on the following cycle.
- req0 and req1 both assert reads, continuously for 4 cycles. Expect grants alternate 0,1,0,1; rvalid follows each grant by 1 cycle with the correct requester's data.
- req0 with lock0 = 1 for 20 cycles, req1 held high. Expect gnt0 for 16 consecutive cycles (MAX_LOCK), then gnt1 for 1 cycle, then gnt0 again.
- req1 writes addr 144 (out of range) with data 16'h1234. Expect gnt1 = 1, mem_en = 0, err1 = 1 the next cycle, rvalid1 = 0; a later read of addr 143 is unaffected.
- req0 locked burst in progress, rst_n pulsed low mid-cycle. Expect gnt*/rvalid*/err* drop to 0 immediately, state returns to RR0, and the first post-reset simultaneous request is granted to requester 0.
- req1 only, with req0 idle for 3 cycles. Expect gnt1 each cycle with no wasted cycles; then req0 asserts and is granted within 1 cycle.

Source files
------------

// File: rtl/dsp_mem_pkg.sv
// dsp_mem_pkg: shared constants, arbiter state type and requester indices for the DSP data memory
package dsp_mem_pkg;
    localparam int AW       = 8;
    localparam int DW       = 16;
    localparam int DEPTH    = 144;
    localparam int MAX_LOCK = 16;
    localparam int CW       = $clog2(MAX_LOCK);
    localparam int REQ_CORE = 0;
    localparam int REQ_HOST = 1;
    typedef enum logic [1:0] {RR0, RR1, LOCK0, LOCK1} arb_state_t;
endpackage

// File: rtl/dmem_rr_pick.sv
// dmem_rr_pick: combinational two-way round-robin/lock grant select producing a one-hot grant
module dmem_rr_pick
    import dsp_mem_pkg::*;
(
    input  arb_state_t state,
    input  logic [1:0] req,
    output logic [1:0] gnt
);
    logic prio;
    // a lock owner that stops requesting hands priority to the other side this very cycle
    always_comb begin
        prio = (state == RR1) || (state == LOCK0 && !req[REQ_CORE]) || (state == LOCK1 && req[REQ_HOST]);
        gnt[REQ_CORE] = req[REQ_CORE] && (!prio || !req[REQ_HOST]);
        gnt[REQ_HOST] = req[REQ_HOST] && (prio || !req[REQ_CORE]);
    end
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin/burst-lock arbiter sharing the single-port DSP data memory between core and host
module dmem_arbiter
    import dsp_mem_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic          lock0,
    input  logic          lock1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          rvalid0,
    output logic          rvalid1,
    output logic [DW-1:0] rdata0,
    output logic [DW-1:0] rdata1,
    output logic          err0,
    output logic          err1,
    output logic          mem_en,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_in,
    input  logic [DW-1:0] mem_out
);
    arb_state_t    state, state_nx;
    logic [CW-1:0] cnt, cnt_nx, base;
    logic [1:0]    req_v, gnt;
    logic          win, win_lock, other_req, win_we, in_range;

    assign req_v = {req1, req0} & {2{rst_n}};

    dmem_rr_pick u_pick (
        .state(state),
        .req  (req_v),
        .gnt  (gnt)
    );

    // winner decode and memory drive; nothing reaches the memory unless granted and in range
    always_comb begin
        gnt0      = gnt[REQ_CORE];
        gnt1      = gnt[REQ_HOST];
        win       = gnt[REQ_HOST];
        win_lock  = win ? lock1 : lock0;
        other_req = win ? req0 : req1;
        win_we    = win ? we1 : we0;
        mem_addr  = gnt[REQ_CORE] ? addr0 : gnt[REQ_HOST] ? addr1 : '0;
        mem_in    = gnt[REQ_CORE] ? wdata0 : gnt[REQ_HOST] ? wdata1 : '0;
        in_range  = mem_addr < AW'(DEPTH);
        mem_en    = |gnt && win_we && in_range;
    end

    // lock bookkeeping: count a burst, release at saturation only if the other side waits
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        base     = (state == (win ? LOCK1 : LOCK0)) ? cnt : '0;
        if (|gnt) begin
            if (win_lock && (base < CW'(MAX_LOCK - 1) || !other_req)) begin
                state_nx = win ? LOCK1 : LOCK0;
                cnt_nx   = (base < CW'(MAX_LOCK - 1)) ? base + 1'b1 : base;
            end else begin
                state_nx = win ? RR0 : RR1;
                cnt_nx   = '0;
            end
        end else if (state == LOCK0 || state == LOCK1) begin
            state_nx = (state == LOCK0) ? RR1 : RR0;
            cnt_nx   = '0;
        end
    end

    // arbiter state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RR0;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // response registers; rdata only moves on a granted read and holds otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            err0    <= 1'b0;
            err1    <= 1'b0;
            rdata0  <= '0;
            rdata1  <= '0;
        end else begin
            rvalid0 <= gnt[REQ_CORE] && !we0 && in_range;
            rvalid1 <= gnt[REQ_HOST] && !we1 && in_range;
            err0    <= gnt[REQ_CORE] && !in_range;
            err1    <= gnt[REQ_HOST] && !in_range;
            if (gnt[REQ_CORE] && !we0) rdata0 <= in_range ? mem_out : '0;
            if (gnt[REQ_HOST] && !we1) rdata1 <= in_range ? mem_out : '0;
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: scoreboard bench for dmem_arbiter with a behavioural memory and arbitration model
module tb_dmem_arbiter;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0, lock0 = 1'b0, lock1 = 1'b0;
    logic [7:0]  addr0 = '0, addr1 = '0, mem_addr;
    logic [15:0] wdata0 = '0, wdata1 = '0, rdata0, rdata1, mem_in, mem_out;
    logic        gnt0, gnt1, rvalid0, rvalid1, err0, err1, mem_en;
    logic [15:0] ram [0:143];
    logic [15:0] mdl [0:143];
    typedef struct { int due; logic rd; logic vld; logic er; logic [15:0] data; } resp_t;
    resp_t q0[$], q1[$];
    int owner = -1, run = 0, prio = 0, cyc = 0, vectors = 0, errors = 0;
    logic seen0, seen1;

    always #5 clk = ~clk;

    dmem_arbiter dut (
        .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .lock0(lock0), .lock1(lock1), .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1), .rdata0(rdata0), .rdata1(rdata1),
        .err0(err0), .err1(err1), .mem_en(mem_en), .mem_addr(mem_addr), .mem_in(mem_in), .mem_out(mem_out)
    );

    always @(posedge clk) if (mem_en) ram[mem_addr] <= mem_in;
    assign mem_out = (mem_addr < 8'd144) ? ram[mem_addr] : 16'h0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // who wins this cycle; a lock owner that stopped requesting forfeits its lock first
    function automatic int pick(input logic r0, input logic r1);
        if (owner >= 0 && !((owner == 1) ? r1 : r0)) begin
            prio  = 1 - owner;
            owner = -1;
            run   = 0;
        end
        if (owner >= 0) return owner;
        if (prio == 0) return r0 ? 0 : (r1 ? 1 : -1);
        return r1 ? 1 : (r0 ? 0 : -1);
    endfunction

    task automatic advance(input int w, input logic lk, input logic other);
        int n;
        if (w < 0) return;
        if (!lk) begin
            owner = -1; run = 0; prio = 1 - w;
            return;
        end
        n = (owner == w ? run : 0) + 1;
        if (n < 16) begin
            owner = w; run = n;
        end else if (!other) begin
            owner = w; run = 15;
        end else begin
            owner = -1; run = 0; prio = 1 - w;
        end
    endtask

    task automatic resp_chk(input int n, input logic rv, input logic er, input logic [15:0] rd);
        resp_t e;
        logic  have;
        e.due = 0; e.rd = 1'b0; e.vld = 1'b0; e.er = 1'b0; e.data = '0;
        have = 1'b0;
        if (n == 0 && q0.size() > 0 && q0[0].due == cyc) begin have = 1'b1; e = q0.pop_front(); end
        if (n == 1 && q1.size() > 0 && q1[0].due == cyc) begin have = 1'b1; e = q1.pop_front(); end
        check(n == 1 ? "rvalid1" : "rvalid0", rv, e.vld);
        check(n == 1 ? "err1" : "err0", er, e.er);
        if (have && e.rd) check(n == 1 ? "rdata1" : "rdata0", rd, e.data);
    endtask

    task automatic cycle(input logic r0, input logic w0, input logic l0, input logic [7:0] a0, input logic [15:0] d0,
                         input logic r1, input logic w1, input logic l1, input logic [7:0] a1, input logic [15:0] d1);
        int          w;
        logic [7:0]  a;
        logic [15:0] d;
        logic        we, inr;
        resp_t       e;
        req0 = r0; we0 = w0; lock0 = l0; addr0 = a0; wdata0 = d0;
        req1 = r1; we1 = w1; lock1 = l1; addr1 = a1; wdata1 = d1;
        w = pick(r0, r1);
        @(negedge clk);
        resp_chk(0, rvalid0, err0, rdata0);
        resp_chk(1, rvalid1, err1, rdata1);
        check("gnt0", gnt0, w == 0);
        check("gnt1", gnt1, w == 1);
        seen0 = gnt0;
        seen1 = gnt1;
        if (w >= 0) begin
            a   = (w == 1) ? a1 : a0;
            d   = (w == 1) ? d1 : d0;
            we  = (w == 1) ? w1 : w0;
            inr = a < 8'd144;
            check("mem_en", mem_en, we && inr);
            check("mem_addr", mem_addr, a);
            if (we) check("mem_in", mem_in, d);
            e.due = cyc + 1; e.rd = !we; e.vld = !we && inr; e.er = !inr;
            e.data = (!we && inr) ? mdl[a] : 16'h0;
            if (!we || !inr) begin
                if (w == 0) q0.push_back(e);
                else q1.push_back(e);
            end
            if (we && inr) mdl[a] = d;
        end else begin
            check("mem_en_idle", mem_en, 1'b0);
            check("mem_addr_idle", mem_addr, 8'h0);
        end
        advance(w, (w == 1) ? l1 : l0, (w == 1) ? r0 : r1);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 1'b0, 8'd0, 16'h0, 1'b0, 1'b0, 1'b0, 8'd0, 16'h0);
    endtask

    initial begin
        logic [3:0] pat;
        int         run0;
        logic       broke;
        for (int i = 0; i < 144; i++) begin
            ram[i] = 16'(i * 257) ^ 16'h5A5A;
            mdl[i] = 16'(i * 257) ^ 16'h5A5A;
        end
        // requests held high during reset must not reach the memory
        req0 = 1'b1; we0 = 1'b1; req1 = 1'b1;
        #2;
        check("rst_gnt0", gnt0, 1'b0);
        check("rst_gnt1", gnt1, 1'b0);
        check("rst_mem_en", mem_en, 1'b0);
        check("rst_rvalid", {rvalid1, rvalid0}, 2'b00);
        check("rst_err", {err1, err0}, 2'b00);
        check("rst_rdata0", rdata0, 16'h0);
        check("rst_rdata1", rdata1, 16'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // write then read back through requester 0
        cycle(1'b1, 1'b1, 1'b0, 8'd5, 16'hBEEF, 1'b0, 1'b0, 1'b0, 8'd0, 16'h0);
        cycle(1'b1, 1'b0, 1'b0, 8'd5, 16'h0, 1'b0, 1'b0, 1'b0, 8'd0, 16'h0);
        idle();
        check("rd_beef", rdata0, 16'hBEEF);

        // one host read to hand priority back to the core, then contention alternates
        cycle(1'b0, 1'b0, 1'b0, 8'd0, 16'h0, 1'b1, 1'b0, 1'b0, 8'd7, 16'h0);
        pat = '0;
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 1'b0, 1'b0, 8'd10, 16'h0, 1'b1, 1'b0, 1'b0, 8'd20, 16'h0);
            pat = {pat[2:0], seen0};
        end
        check("alternate", pat, 4'b1010);
        idle();

        // locked burst against a waiting host: 16 grants, forced release, then core again
        run0 = 0;
        broke = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, 1'b0, 1'b1, 8'(30 + i), 16'h0, 1'b1, 1'b0, 1'b0, 8'd40, 16'h0);
            if (!broke && seen0) run0++;
            else broke = 1'b1;
            if (i == 16) check("release_to_host", seen1, 1'b1);
            if (i == 17) check("core_after_release", seen0, 1'b1);
        end
        check("lock_run", run0, 16);
        idle();

        // lock owner drops its request: the other side is served at once
        cycle(1'b1, 1'b0, 1'b1, 8'd3, 16'h0, 1'b0, 1'b0, 1'b0, 8'd0, 16'h0);
        cycle(1'b0, 1'b0, 1'b0, 8'd0, 16'h0, 1'b1, 1'b0, 1'b0, 8'd4, 16'h0);
        idle();

        // out-of-range accesses and the top valid word
        cycle(1'b0, 1'b0, 1'b0, 8'd0, 16'h0, 1'b1, 1'b1, 1'b0, 8'd144, 16'h1234);
        cycle(1'b0, 1'b0, 1'b0, 8'd0, 16'h0, 1'b1, 1'b0, 1'b0, 8'd143, 16'h0);
        cycle(1'b0, 1'b0, 1'b0, 8'd0, 16'h0, 1'b1, 1'b0, 1'b0, 8'd200, 16'h0);
        cycle(1'b0, 1'b0, 1'b0, 8'd0, 16'h0, 1'b1, 1'b1, 1'b0, 8'd143, 16'hA5C3);
        cycle(1'b0, 1'b0, 1'b0, 8'd0, 16'h0, 1'b1, 1'b0, 1'b0, 8'd143, 16'h0);
        idle();
        check("rd_143", rdata1, 16'hA5C3);

        // saturated lock with nobody waiting holds, then yields once the host shows up
        for (int i = 0; i < 18; i++) cycle(1'b1, 1'b0, 1'b1, 8'd50, 16'h0, 1'b0, 1'b0, 1'b0, 8'd0, 16'h0);
        cycle(1'b1, 1'b0, 1'b1, 8'd50, 16'h0, 1'b1, 1'b0, 1'b0, 8'd60, 16'h0);
        check("sat_hold_core", seen0, 1'b1);
        cycle(1'b1, 1'b0, 1'b1, 8'd50, 16'h0, 1'b1, 1'b0, 1'b0, 8'd60, 16'h0);
        check("sat_yield_host", seen1, 1'b1);
        idle();

        // host alone back-to-back, then the core joins and wins the next slot
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, 8'd0, 16'h0, 1'b1, 1'b0, 1'b0, 8'(70 + i), 16'h0);
        cycle(1'b1, 1'b0, 1'b0, 8'd80, 16'h0, 1'b1, 1'b0, 1'b0, 8'd73, 16'h0);
        check("core_join", seen0, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 8'd0, 16'h0, 1'b1, 1'b0, 1'b0, 8'd73, 16'h0);
        idle();

        // reset pulse in the middle of a locked read burst
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b1, 8'd5, 16'h0, 1'b0, 1'b0, 1'b0, 8'd0, 16'h0);
        check("pre_rst_rvalid0", rvalid0, 1'b1);
        check("pre_rst_gnt0", gnt0, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_gnt0", gnt0, 1'b0);
        check("mid_rst_gnt1", gnt1, 1'b0);
        check("mid_rst_mem_en", mem_en, 1'b0);
        check("mid_rst_rvalid0", rvalid0, 1'b0);
        check("mid_rst_err", {err1, err0}, 2'b00);
        check("mid_rst_rdata0", rdata0, 16'h0);
        q0.delete();
        q1.delete();
        owner = -1; run = 0; prio = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc++;
        cycle(1'b1, 1'b0, 1'b0, 8'd10, 16'h0, 1'b1, 1'b0, 1'b0, 8'd20, 16'h0);
        check("post_rst_core_wins", seen0, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 8'd0, 16'h0, 1'b1, 1'b0, 1'b0, 8'd20, 16'h0);
        idle();
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
